mem_ctrl: RTL and testbench

Single-port memory controller that arbitrates between instruction fetch (IF) and the MEM stage for one byte-wide synchronous RAM port. It serialises 1/2/4-byte accesses into per-byte RAM cycles and assembles or splits 32-bit words little-endian. It returns one-cycle done pulses that the stall logic uses to release the pipeline registers. It sits between the IF/MEM stages and the external RAM/IO bus.

---
 rtl/mem_ctrl_if.sv | 45 ++++
 rtl/mem_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module   : mem_ctrl_if
// Brief    : IF/MEM request bundle and byte-wide RAM port seen by mem_ctrl.
// Revision : 1.0 - initial release
// =============================================================================
interface mem_ctrl_if;
    // Instruction fetch side
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_cancel;
    logic [31:0] if_data;
    logic        if_done;
    // MEM stage side
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_length;
    logic        mem_signed;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    // Byte-wide synchronous RAM / IO port
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_addr;
    logic        ram_wr;

    modport slave (
        input  if_req, if_addr, if_cancel,
        input  mem_req, mem_we, mem_length, mem_signed, mem_addr, mem_wdata,
        input  ram_din,
        output if_data, if_done, mem_rdata, mem_done,
        output ram_dout, ram_addr, ram_wr
    );

    modport master (
        output if_req, if_addr, if_cancel,
        output mem_req, mem_we, mem_length, mem_signed, mem_addr, mem_wdata,
        output ram_din,
        input  if_data, if_done, mem_rdata, mem_done,
        input  ram_dout, ram_addr, ram_wr
    );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : mem_ctrl
// Brief    : Arbitrates IF/MEM onto one byte-wide RAM port, serialising
//            1/2/4-byte accesses little-endian. Optional macro
//            MEM_CTRL_IO_STALL_EN adds the io_buffer_full store back-pressure.
// Revision : 1.0 - initial release
// =============================================================================
module mem_ctrl (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rdy,
`ifdef MEM_CTRL_IO_STALL_EN
    input  logic      io_buffer_full,
`endif
    mem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_q,     state_d;
    logic [1:0]  idx_q,       idx_d;
    logic [2:0]  step_q,      step_d;
    logic [2:0]  len_q,       len_d;
    logic [31:0] base_q,      base_d;
    logic [31:0] wdata_q,     wdata_d;
    logic [31:0] buf_q,       buf_d;
    logic        src_if_q,    src_if_d;
    logic        sgn_q,       sgn_d;
    logic        wr_q,        wr_d;
    logic [31:0] ram_addr_q,  ram_addr_d;
    logic [7:0]  ram_dout_q,  ram_dout_d;
    logic [31:0] if_data_q,   if_data_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_done_q,   if_done_d;
    logic        mem_done_q,  mem_done_d;

    logic [2:0]  w_mem_len;
    logic        w_io_block;
    logic [1:0]  w_next_idx;
    logic        w_more;
    logic [1:0]  w_cap_idx;
    logic [31:0] w_cap_word;
    logic [31:0] w_wr_shift;

    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [2:0]  len,
                                                input logic        sgn);
        logic [31:0] res;
        case (len)
            3'd1:    res = {{24{sgn & raw[7]}},  raw[7:0]};
            3'd2:    res = {{16{sgn & raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    always_comb begin
        case (bus.mem_length)
            2'b00:   w_mem_len = 3'd1;
            2'b01:   w_mem_len = 3'd2;
            default: w_mem_len = 3'd4;
        endcase
    end

`ifdef MEM_CTRL_IO_STALL_EN
    // Stores into the IO window (addr[17:16]==3) wait while the IO buffer is full
    assign w_io_block = bus.mem_we && (bus.mem_addr[17:16] == 2'b11) && io_buffer_full;
`else
    assign w_io_block = 1'b0;
`endif

    assign w_next_idx = idx_q + 2'd1;
    assign w_more     = (({1'b0, idx_q} + 3'd1) < len_q);
    assign w_wr_shift = wdata_q >> {w_next_idx, 3'b000};

    // step_q counts READ edges; byte (step_q-1) arrives once the RAM latency has elapsed
    assign w_cap_idx  = step_q[1:0] - 2'd1;

    always_comb begin
        w_cap_word = buf_q;
        w_cap_word[{w_cap_idx, 3'b000} +: 8] = bus.ram_din;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        step_d      = step_q;
        len_d       = len_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        src_if_d    = src_if_q;
        sgn_d       = sgn_q;
        wr_d        = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_dout_d  = ram_dout_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.mem_req && !w_io_block) begin
                    src_if_d   = 1'b0;
                    sgn_d      = bus.mem_signed;
                    len_d      = w_mem_len;
                    base_d     = bus.mem_addr;
                    wdata_d    = bus.mem_wdata;
                    idx_d      = 2'd0;
                    step_d     = 3'd0;
                    buf_d      = 32'd0;
                    ram_addr_d = bus.mem_addr;
                    if (bus.mem_we) begin
                        state_d    = ST_WRITE;
                        wr_d       = 1'b1;
                        ram_dout_d = bus.mem_wdata[7:0];
                    end else begin
                        state_d    = ST_READ;
                    end
                end else if (bus.if_req) begin
                    src_if_d   = 1'b1;
                    sgn_d      = 1'b0;
                    len_d      = 3'd4;
                    base_d     = bus.if_addr;
                    idx_d      = 2'd0;
                    step_d     = 3'd0;
                    buf_d      = 32'd0;
                    ram_addr_d = bus.if_addr;
                    state_d    = ST_READ;
                end
            end

            ST_READ: begin
                if (src_if_q && bus.if_cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    step_d = step_q + 3'd1;
                    if (w_more) begin
                        idx_d      = w_next_idx;
                        ram_addr_d = base_q + {30'd0, w_next_idx};
                    end
                    if (step_q != 3'd0) begin
                        buf_d = w_cap_word;
                        if (step_q == len_q) begin
                            state_d = ST_DONE;
                            if (src_if_q) begin
                                if_data_d = w_cap_word;
                                if_done_d = 1'b1;
                            end else begin
                                mem_rdata_d = extend_load(w_cap_word, len_q, sgn_q);
                                mem_done_d  = 1'b1;
                            end
                        end
                    end
                end
            end

            ST_WRITE: begin
                if (w_more) begin
                    idx_d      = w_next_idx;
                    ram_addr_d = base_q + {30'd0, w_next_idx};
                    ram_dout_d = w_wr_shift[7:0];
                    wr_d       = 1'b1;
                end else begin
                    state_d    = ST_DONE;
                    mem_done_d = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // rdy low freezes every register, which also holds the done pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            step_q      <= 3'd0;
            len_q       <= 3'd0;
            base_q      <= 32'd0;
            wdata_q     <= 32'd0;
            buf_q       <= 32'd0;
            src_if_q    <= 1'b0;
            sgn_q       <= 1'b0;
            wr_q        <= 1'b0;
            ram_addr_q  <= 32'd0;
            ram_dout_q  <= 8'd0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else if (rdy) begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            step_q      <= step_d;
            len_q       <= len_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            src_if_q    <= src_if_d;
            sgn_q       <= sgn_d;
            wr_q        <= wr_d;
            ram_addr_q  <= ram_addr_d;
            ram_dout_q  <= ram_dout_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    assign bus.if_data   = if_data_q;
    // A flush arriving in the fetch's DONE cycle still hides the completion
    assign bus.if_done   = if_done_q & ~bus.if_cancel;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.mem_done  = mem_done_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_dout  = ram_dout_q;
    assign bus.ram_wr    = wr_q & rdy;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_mem_ctrl
// Brief    : Self-checking bench for mem_ctrl: vector table, corner sequences
//            and random transactions against a byte-array reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_mem_ctrl;

    logic clk;
    logic rst_n;
    logic rdy;
`ifdef MEM_CTRL_IO_STALL_EN
    logic io_buffer_full;
`endif

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rdy            (rdy),
`ifdef MEM_CTRL_IO_STALL_EN
        .io_buffer_full (io_buffer_full),
`endif
        .bus            (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int if_done_cnt = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;
    wr_t wlog[$];

    logic [7:0] env_ram [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] env_rd(input logic [31:0] a);
        return env_ram.exists(a) ? env_ram[a] : dflt(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Synchronous byte RAM: data for the address seen at an edge appears after it
    always @(posedge clk) begin
        bus.ram_din <= env_rd(bus.ram_addr);
        if (bus.ram_wr) begin
            env_ram[bus.ram_addr] = bus.ram_dout;
            wlog.push_back('{addr: bus.ram_addr, data: bus.ram_dout});
        end
    end

    always @(posedge clk) if (bus.if_done) if_done_cnt <= if_done_cnt + 1;

    function automatic int nbytes(input logic [1:0] c);
        return (c == 2'd0) ? 1 : (c == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input bit sgn);
        logic [31:0] w;
        w = 32'd0;
        for (int k = 0; k < n; k++) w = w | (32'(ref_rd(a + 32'(k))) << (8 * k));
        if (sgn && n < 4 && w[8*n-1]) w = w | (32'hFFFF_FFFF << (8 * n));
        return w;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input int n);
        for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = 8'((wd >> (8 * k)) & 32'hFF);
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        env_ram[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_writes(input string tag, input logic [31:0] a, input logic [31:0] wd, input int n);
        chk({tag, "_wcount"}, 32'(wlog.size()), 32'(n));
        for (int k = 0; k < n && k < wlog.size(); k++) begin
            chk({tag, "_waddr"}, wlog[k].addr, a + 32'(k));
            chk({tag, "_wdata"}, 32'(wlog[k].data), (wd >> (8 * k)) & 32'hFF);
        end
    endtask

    // Starts and ends at a negedge with the controller in IDLE
    task automatic run_txn(input string tag, input bit is_if, input bit we, input logic [1:0] len,
                           input bit sgn, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        rd  = 32'd0;
        if (is_if) begin
            bus.if_req  = 1'b1;
            bus.if_addr = a;
        end else begin
            bus.mem_req    = 1'b1;
            bus.mem_we     = we;
            bus.mem_length = len;
            bus.mem_signed = sgn;
            bus.mem_addr   = a;
            bus.mem_wdata  = wd;
        end
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            bus.if_req  = 1'b0;
            bus.mem_req = 1'b0;
            if (is_if ? bus.if_done : bus.mem_done) begin
                got = 1'b1;
                rd  = is_if ? bus.if_data : bus.mem_rdata;
            end
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        @(negedge clk);
        chk({tag, "_done_width"}, 32'(is_if ? bus.if_done : bus.mem_done), 32'd0);
    endtask

    typedef struct {
        string       name;
        bit          is_if;
        logic [1:0]  len;
        bit          sgn;
        logic [31:0] addr;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[10];

    logic [31:0] rd;
    int          lat;
    int          cnt0;
    int          mem_at;
    int          if_at;
    bit          got;
    bit          r_is_if;
    bit          r_we;
    bit          r_sgn;
    logic [1:0]  r_len;
    logic [31:0] r_addr;
    logic [31:0] r_wd;
    int          r_n;

    initial begin
        rst_n          = 1'b0;
        rdy            = 1'b1;
        bus.if_req     = 1'b0;
        bus.if_addr    = 32'd0;
        bus.if_cancel  = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_length = 2'd0;
        bus.mem_signed = 1'b0;
        bus.mem_addr   = 32'd0;
        bus.mem_wdata  = 32'd0;
`ifdef MEM_CTRL_IO_STALL_EN
        io_buffer_full = 1'b0;
`endif
        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'h00); preload(32'h103, 8'h00);
        preload(32'h400, 8'h80); preload(32'h402, 8'h01); preload(32'h403, 8'h80);
        preload(32'h404, 8'h7F);
        preload(32'h408, 8'h11); preload(32'h409, 8'h22);
        preload(32'h40A, 8'h33); preload(32'h40B, 8'h84);
        preload(32'hFFFF_FFFE, 8'hA1); preload(32'hFFFF_FFFF, 8'hB2);
        preload(32'h0000_0000, 8'hC3); preload(32'h0000_0001, 8'hD4);

        vecs[0] = '{"fetch_word",     1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'h0000_0513};
        vecs[1] = '{"lb_signed",      1'b0, 2'd0, 1'b1, 32'h0000_0400, 32'hFFFF_FF80};
        vecs[2] = '{"lb_unsigned",    1'b0, 2'd0, 1'b0, 32'h0000_0400, 32'h0000_0080};
        vecs[3] = '{"lh_signed",      1'b0, 2'd1, 1'b1, 32'h0000_0402, 32'hFFFF_8001};
        vecs[4] = '{"lh_unsigned",    1'b0, 2'd1, 1'b0, 32'h0000_0402, 32'h0000_8001};
        vecs[5] = '{"lb_signed_pos",  1'b0, 2'd0, 1'b1, 32'h0000_0404, 32'h0000_007F};
        vecs[6] = '{"lw",             1'b0, 2'd2, 1'b0, 32'h0000_0408, 32'h8433_2211};
        vecs[7] = '{"lw_len3_signed", 1'b0, 2'd3, 1'b1, 32'h0000_0408, 32'h8433_2211};
        vecs[8] = '{"lw_wrap",        1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'hD4C3_B2A1};
        vecs[9] = '{"fetch_wrap",     1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'hD4C3_B2A1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_if_data",   bus.if_data,          32'd0);
        chk("reset_if_done",   32'(bus.if_done),     32'd0);
        chk("reset_mem_rdata", bus.mem_rdata,        32'd0);
        chk("reset_mem_done",  32'(bus.mem_done),    32'd0);
        chk("reset_ram_addr",  bus.ram_addr,         32'd0);
        chk("reset_ram_dout",  32'(bus.ram_dout),    32'd0);
        chk("reset_ram_wr",    32'(bus.ram_wr),      32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].name, vecs[i].is_if, 1'b0, vecs[i].len, vecs[i].sgn, vecs[i].addr,
                    32'd0, rd, lat);
            chk({vecs[i].name, "_data"}, rd, vecs[i].exp);
            chk({vecs[i].name, "_latency"}, 32'(lat),
                32'((vecs[i].is_if ? 4 : nbytes(vecs[i].len)) + 2));
        end

        // MEM store and IF fetch requested together: store first, then fetch
        wlog.delete();
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_length = 2'd2; bus.mem_signed = 1'b0;
        bus.mem_addr = 32'h200; bus.mem_wdata = 32'hDEAD_BEEF;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        mem_at = 0; if_at = 0; rd = 32'd0;
        for (int c = 1; c <= 40 && if_at == 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            bus.mem_req = 1'b0;
            if (bus.mem_done && mem_at == 0) mem_at = c;
            if (bus.if_done) begin
                if_at = c;
                rd = bus.if_data;
                bus.if_req = 1'b0;
            end
        end
        bus.if_req = 1'b0;
        @(negedge clk);
        chk("arb_mem_done_cycle", 32'(mem_at), 32'd5);
        chk("arb_if_done_cycle",  32'(if_at),  32'd12);
        chk("arb_if_data",        rd,          32'h0000_0513);
        chk_writes("arb_store", 32'h200, 32'hDEAD_BEEF, 4);
        ref_store(32'h200, 32'hDEAD_BEEF, 4);

        // rdy low for three cycles in the middle of a word store
        wlog.delete();
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_length = 2'd2;
        bus.mem_addr = 32'h300; bus.mem_wdata = 32'h1122_3344;
        @(posedge clk); @(negedge clk);
        bus.mem_req = 1'b0;
        @(posedge clk); @(negedge clk);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rdy_hold_ram_wr",   32'(bus.ram_wr), 32'd0);
            chk("rdy_hold_ram_addr", bus.ram_addr,    32'h301);
            @(negedge clk);
        end
        rdy = 1'b1;
        #1;
        chk("rdy_resume_ram_wr",   32'(bus.ram_wr),   32'd1);
        chk("rdy_resume_ram_dout", 32'(bus.ram_dout), 32'h33);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus.mem_done) got = 1'b1;
        end
        chk("rdy_store_done", 32'(got), 32'd1);
        @(negedge clk);
        chk_writes("rdy_store", 32'h300, 32'h1122_3344, 4);
        ref_store(32'h300, 32'h1122_3344, 4);

        // Fetch cancelled at idx=2, then a MEM load right away
        cnt0 = if_done_cnt;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        @(posedge clk); @(negedge clk);
        bus.if_req = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("cancel_addr_idx2", bus.ram_addr, 32'h102);
        bus.if_cancel = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.if_cancel = 1'b0;
        chk("cancel_addr_hold", bus.ram_addr, 32'h102);
        run_txn("after_cancel", 1'b0, 1'b0, 2'd0, 1'b0, 32'h400, 32'd0, rd, lat);
        chk("after_cancel_data",    rd,           32'h0000_0080);
        chk("after_cancel_latency", 32'(lat),     32'd3);
        chk("cancel_no_if_done",    32'(if_done_cnt), 32'(cnt0));

`ifdef MEM_CTRL_IO_STALL_EN
        wlog.delete();
        io_buffer_full = 1'b1;
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_length = 2'd0;
        bus.mem_addr = 32'h0003_0000; bus.mem_wdata = 32'h0000_005A;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            chk("io_stall_no_done", 32'(bus.mem_done), 32'd0);
        end
        chk("io_stall_no_write", 32'(wlog.size()), 32'd0);
        io_buffer_full = 1'b0;
        run_txn("io_store", 1'b0, 1'b1, 2'd0, 1'b0, 32'h0003_0000, 32'h0000_005A, rd, lat);
        chk("io_store_latency", 32'(lat), 32'd2);
        chk_writes("io_store", 32'h0003_0000, 32'h0000_005A, 1);
        ref_store(32'h0003_0000, 32'h0000_005A, 1);
`endif

        for (int t = 0; t < 60; t++) begin
            r_is_if = ($urandom_range(0, 3) == 0);
            r_we    = r_is_if ? 1'b0 : 1'($urandom_range(0, 1));
            r_len   = r_is_if ? 2'd2 : 2'($urandom_range(0, 3));
            r_sgn   = 1'($urandom_range(0, 1));
            r_addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                  : 32'h0000_1000 + 32'($urandom_range(0, 31));
            r_wd    = $urandom;
            r_n     = r_is_if ? 4 : nbytes(r_len);
            wlog.delete();
            run_txn("rand", r_is_if, r_we, r_len, r_sgn, r_addr, r_wd, rd, lat);
            if (r_we) begin
                chk("rand_store_latency", 32'(lat), 32'(r_n + 1));
                chk_writes("rand_store", r_addr, r_wd, r_n);
                ref_store(r_addr, r_wd, r_n);
            end else begin
                chk("rand_load_latency", 32'(lat), 32'(r_n + 2));
                chk("rand_load_data", rd, ref_load(r_addr, r_n, r_sgn && !r_is_if));
                chk("rand_no_write", 32'(wlog.size()), 32'd0);
            end
        end

        // Asynchronous reset in the middle of a fetch
        bus.if_req = 1'b1; bus.if_addr = 32'h408;
        @(posedge clk); @(negedge clk);
        bus.if_req = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_if_data",   bus.if_data,       32'd0);
        chk("midrst_if_done",   32'(bus.if_done),  32'd0);
        chk("midrst_mem_rdata", bus.mem_rdata,     32'd0);
        chk("midrst_mem_done",  32'(bus.mem_done), 32'd0);
        chk("midrst_ram_addr",  bus.ram_addr,      32'd0);
        chk("midrst_ram_dout",  32'(bus.ram_dout), 32'd0);
        chk("midrst_ram_wr",    32'(bus.ram_wr),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn("post_reset", 1'b0, 1'b0, 2'd0, 1'b1, 32'h404, 32'd0, rd, lat);
        chk("post_reset_data",    rd,       32'h0000_007F);
        chk("post_reset_latency", 32'(lat), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
